// File: rtl/iir_out_pacer.sv
// iir_out_pacer: output-side rate regulator for the IIR datapath.
// Converts Q2.22 filter samples to Q1.15 (round half up, saturate) on FIFO write
// and replays them to a parallel DAC at one word every INTERVAL clocks.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   data_in, valid_in     24-bit Q2.22 sample and its single-cycle strobe
//   clr                   synchronous clear of status (FIFO contents untouched)
//   dac_data, dac_strobe  16-bit Q1.15 DAC word and its one-cycle strobe
//   running               pacer is in RUN
//   fifo_level            current FIFO occupancy
//   ovf, unf              sticky overflow / underflow flags
//   in_cnt, out_cnt       input pulses seen / strobes issued
//   max_gap               largest distance between consecutive valid_in
module iir_out_pacer #(
    parameter int unsigned INTERVAL = 10,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PRIME    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [23:0]              data_in,
    input  logic                     valid_in,
    input  logic                     clr,
    output logic [15:0]              dac_data,
    output logic                     dac_strobe,
    output logic                     running,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf,
    output logic                     unf,
    output logic [31:0]              in_cnt,
    output logic [31:0]              out_cnt,
    output logic [15:0]              max_gap
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    localparam logic signed [24:0] T_MAX = 25'sd32767;
    localparam logic signed [24:0] T_MIN = -25'sd32768;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;

    logic [15:0]     mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [AW:0]     wr_ptr_nx, rd_ptr_nx;

    logic signed [24:0] sum_ext;
    logic signed [24:0] t_shift;
    logic [15:0]        word_q15;

    logic full, empty, pop_due, pop, wr_en, underflow;

    logic [15:0]     gap_cnt;
    logic            gap_armed;

    // Round half up on the 7 dropped fraction bits, then saturate to Q1.15
    always_comb begin
        sum_ext = $signed({data_in[23], data_in}) + 25'sd64;
        t_shift = sum_ext >>> 7;
        if (t_shift > T_MAX) begin
            word_q15 = 16'h7FFF;
        end else if (t_shift < T_MIN) begin
            word_q15 = 16'h8000;
        end else begin
            word_q15 = t_shift[15:0];
        end
    end

    // FIFO handshake; a pop frees a slot for a same-cycle write when full
    always_comb begin
        full      = (fifo_level == LW'(DEPTH));
        empty     = (fifo_level == '0);
        pop_due   = (state == RUN) && (cnt == '0);
        pop       = pop_due && !empty;
        underflow = pop_due && empty;
        wr_en     = valid_in && (!full || pop);
        wr_ptr_nx = wr_en ? (wr_ptr + LW'(1)) : wr_ptr;
        rd_ptr_nx = pop   ? (rd_ptr + LW'(1)) : rd_ptr;
    end

    // Pacer state machine: prime to PRIME words, then pop every INTERVAL clocks
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (fifo_level >= LW'(PRIME)) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                cnt_next = (cnt == CW'(INTERVAL - 1)) ? '0 : (cnt + CW'(1));
                if (underflow) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            running <= (state_next == RUN);
        end
    end

    // FIFO storage and pointers; the extra pointer bit separates full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= word_q15;
            end
            wr_ptr     <= wr_ptr_nx;
            rd_ptr     <= rd_ptr_nx;
            fifo_level <= wr_ptr_nx - rd_ptr_nx;
        end
    end

    // DAC output register; dac_data holds between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_data   <= '0;
            dac_strobe <= 1'b0;
        end else begin
            dac_strobe <= pop;
            if (pop) begin
                dac_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // Status; clr takes priority over any same-cycle event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf       <= 1'b0;
            unf       <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            max_gap   <= '0;
            gap_cnt   <= '0;
            gap_armed <= 1'b0;
        end else if (clr) begin
            ovf       <= 1'b0;
            unf       <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            max_gap   <= '0;
            gap_cnt   <= '0;
            gap_armed <= 1'b0;
        end else begin
            if (valid_in && full && !pop) begin
                ovf <= 1'b1;
            end
            if (underflow) begin
                unf <= 1'b1;
            end
            if (valid_in) begin
                in_cnt <= in_cnt + 32'd1;
            end
            if (pop) begin
                out_cnt <= out_cnt + 32'd1;
            end
            // gap_cnt holds the distance from the last pulse to the current cycle
            if (valid_in) begin
                gap_armed <= 1'b1;
                gap_cnt   <= 16'd1;
                if (gap_armed && (gap_cnt > max_gap)) begin
                    max_gap <= gap_cnt;
                end
            end else if (gap_armed && (gap_cnt != 16'hFFFF)) begin
                gap_cnt <= gap_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_iir_out_pacer.sv
// Scoreboard bench for iir_out_pacer: stimulus pushes the hand-computed DAC word
// for every accepted sample; the monitor pops and compares on each dac_strobe and
// also checks strobe spacing and first-strobe latency.
module tb_iir_out_pacer;

    localparam int unsigned INTERVAL = 10;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned PRIME    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] data_in;
    logic        valid_in;
    logic        clr;
    logic [15:0] dac_data;
    logic        dac_strobe;
    logic        running;
    logic [3:0]  fifo_level;
    logic        ovf;
    logic        unf;
    logic [31:0] in_cnt;
    logic [31:0] out_cnt;
    logic [15:0] max_gap;

    iir_out_pacer #(
        .INTERVAL(INTERVAL),
        .DEPTH   (DEPTH),
        .PRIME   (PRIME)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .clr       (clr),
        .dac_data  (dac_data),
        .dac_strobe(dac_strobe),
        .running   (running),
        .fifo_level(fifo_level),
        .ovf       (ovf),
        .unf       (unf),
        .in_cnt    (in_cnt),
        .out_cnt   (out_cnt),
        .max_gap   (max_gap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] sb[$];
    int          exp_first   = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        valid_in = 1'b0;
        clr      = 1'b0;
        sb.delete();
        exp_first = -1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One valid_in pulse, then gap-1 idle cycles so the next pulse lands gap cycles later
    task automatic send(input logic [23:0] d, input logic [15:0] w, input int gap,
                        input bit push, input bit arm);
        data_in  = d;
        valid_in = 1'b1;
        if (push) sb.push_back(w);
        if (arm) exp_first = cyc + 3;
        tick();
        valid_in = 1'b0;
        repeat (gap - 1) tick();
    endtask

    // Wait for all expected words to be strobed out, then for the re-prime to IDLE
    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        if (sb.size() != 0) fail_now({name, "_drain_timeout"});
        n = 0;
        while (running && n < 100) begin
            tick();
            n++;
        end
        if (running) fail_now({name, "_idle_timeout"});
        if (exp_first != -1) begin
            fail_now({name, "_first_strobe_missing"});
            exp_first = -1;
        end
    endtask

    // Monitor: compare each strobed word against the scoreboard head
    initial begin
        int          prev;
        logic [15:0] e;
        prev = -1;
        forever begin
            @(negedge clk);
            if (!rst_n || !running) prev = -1;
            if (rst_n && dac_strobe) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_strobe");
                end else begin
                    e = sb.pop_front();
                    chk("dac_data", 32'(dac_data), 32'(e));
                end
                if (prev >= 0) chk("strobe_interval", 32'(cyc - prev), 32'(INTERVAL));
                if (exp_first >= 0) begin
                    chk("first_strobe_cycle", 32'(cyc), 32'(exp_first));
                    exp_first = -1;
                end
                prev = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [23:0] conv_d [9];
    logic [15:0] conv_w [9];

    initial begin
        int s;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        clr      = 1'b0;
        data_in  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dac_data", 32'(dac_data), 32'h0);
        chk("rst_dac_strobe", 32'(dac_strobe), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_fifo_level", 32'(fifo_level), 32'h0);
        chk("rst_ovf_unf", {30'h0, ovf, unf}, 32'h0);
        chk("rst_in_cnt", in_cnt, 32'h0);
        chk("rst_out_cnt", out_cnt, 32'h0);
        chk("rst_max_gap", 32'(max_gap), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Steady input: 0x200000 every 10 cycles -> 0x4000
        for (int i = 0; i < 99; i++) send(24'h200000, 16'h4000, 10, 1'b1, i == 3);
        send(24'h200000, 16'h4000, 1, 1'b1, 1'b0);
        @(negedge clk);
        chk("steady_level", 32'(fifo_level), 32'd4);
        chk("steady_out_cnt", out_cnt, 32'd96);
        chk("steady_in_cnt", in_cnt, 32'd100);
        chk("steady_ovf_unf", {30'h0, ovf, unf}, 32'h0);
        chk("steady_max_gap", 32'(max_gap), 32'd10);
        drain("steady");

        // Conversion: rounding and saturation
        conv_d[0] = 24'h400000; conv_w[0] = 16'h7FFF;
        conv_d[1] = 24'h3FFFC0; conv_w[1] = 16'h7FFF;
        conv_d[2] = 24'hC00000; conv_w[2] = 16'h8000;
        conv_d[3] = 24'h000040; conv_w[3] = 16'h0001;
        conv_d[4] = 24'h00003F; conv_w[4] = 16'h0000;
        conv_d[5] = 24'hFFFFC0; conv_w[5] = 16'h0000;
        conv_d[6] = 24'hFFFFBF; conv_w[6] = 16'hFFFF;
        conv_d[7] = 24'h800000; conv_w[7] = 16'h8000;
        conv_d[8] = 24'h123456; conv_w[8] = 16'h2469;
        reset_dut();
        for (int i = 0; i < 9; i++) send(conv_d[i], conv_w[i], 10, 1'b1, i == 3);
        drain("conv");

        // Jitter: gaps alternate 9 and 11
        reset_dut();
        for (int i = 0; i < 20; i++)
            send(24'(i * 128), 16'(i), (i % 2 == 0) ? 9 : 11, 1'b1, i == 3);
        chk("jitter_max_gap", 32'(max_gap), 32'd11);
        chk("jitter_ovf_unf", {30'h0, ovf, unf}, 32'h0);
        chk("jitter_in_cnt", in_cnt, 32'd20);
        drain("jitter");

        // Overflow: 12 back-to-back inputs from reset, cycles 9..11 dropped
        reset_dut();
        s = cyc;
        for (int i = 0; i < 12; i++) begin
            data_in  = 24'(i * 128);
            valid_in = 1'b1;
            if (i < 9) sb.push_back(16'(i));
            if (i == 3) exp_first = cyc + 3;
            if (i == 9 || i == 10) begin
                @(negedge clk);
                chk("ovf_timing", 32'(ovf), (i == 10) ? 32'd1 : 32'd0);
            end
            tick();
        end
        valid_in = 1'b0;
        @(negedge clk);
        chk("ovf_cycle_ref", 32'(cyc - s), 32'd12);
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_in_cnt", in_cnt, 32'd12);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_max_gap", 32'(max_gap), 32'd1);
        drain("ovf");

        // Underflow and re-prime
        reset_dut();
        for (int i = 0; i < 20; i++) send(24'((100 + i) * 128), 16'(100 + i), 10, 1'b1, i == 3);
        drain("unf");
        chk("unf_flag", 32'(unf), 32'd1);
        chk("unf_running", 32'(running), 32'd0);
        chk("unf_hold", 32'(dac_data), 32'd119);
        chk("unf_out_cnt", out_cnt, 32'd20);
        for (int i = 0; i < 6; i++) send(24'((200 + i) * 128), 16'(200 + i), 10, 1'b1, i == 3);
        drain("reprime");
        chk("reprime_out_cnt", out_cnt, 32'd26);
        chk("reprime_unf_sticky", 32'(unf), 32'd1);

        // Reset mid-RUN
        reset_dut();
        for (int i = 0; i < 6; i++) send(24'((i + 1) * 128), 16'(i + 1), 10, 1'b1, i == 3);
        chk("midrun_running", 32'(running), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        exp_first = -1;
        #1;
        chk("midrun_rst_running", 32'(running), 32'd0);
        chk("midrun_rst_level", 32'(fifo_level), 32'd0);
        chk("midrun_rst_dac", {15'h0, dac_strobe, dac_data}, 32'h0);
        chk("midrun_rst_cnts", in_cnt | out_cnt | 32'(max_gap), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("midrun_post_level", 32'(fifo_level), 32'd0);
        chk("midrun_post_running", 32'(running), 32'd0);

        // Clear with ovf set: status clears, FIFO level untouched
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            data_in  = 24'(i * 128);
            valid_in = 1'b1;
            if (i < 9) sb.push_back(16'(i));
            if (i == 3) exp_first = cyc + 3;
            tick();
        end
        valid_in = 1'b0;
        chk("clr_pre_ovf", 32'(ovf), 32'd1);
        chk("clr_pre_out_cnt", out_cnt, 32'd1);
        chk("clr_pre_level", 32'(fifo_level), 32'd8);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_in_cnt", in_cnt, 32'd0);
        chk("clr_out_cnt", out_cnt, 32'd0);
        chk("clr_max_gap", 32'(max_gap), 32'd0);
        chk("clr_level", 32'(fifo_level), 32'd8);
        drain("clr");
        chk("clr_post_out_cnt", out_cnt, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iir_out_pacer.md
# iir_out_pacer

Output-side rate regulator for the opti IIR datapath. It takes the filter's 24-bit Q2.22 result stream (`data_out`/`valid_out` of `opti_top`) and converts each sample to 16-bit Q1.15 with rounding and saturation. Samples are buffered in a small FIFO and replayed to a parallel DAC at a fixed strobe period, one sample every INTERVAL clocks (15 MHz at 150 MHz clk), which absorbs pipeline jitter. It also keeps throughput and health status for bring-up.

## Interface
- INTERVAL, 10, clk cycles between DAC strobes (≥2)
- DEPTH, 8, FIFO entries (power of two)
- PRIME, 4, FIFO level required before output starts (1..DEPTH)
- clk  in  1  system clock, 150 MHz
- rst_n  in  1  reset, asynchronous, active-low
- data_in  in  24  signed Q2.22 sample from the filter
- valid_in  in  1  single-cycle sample strobe
- clr  in  1  synchronous clear of status (ovf, unf, in_cnt, out_cnt, max_gap); does not flush the FIFO
- dac_data  out  16  signed Q1.15 DAC word, held between strobes
- dac_strobe  out  1  one-cycle pulse; dac_data is valid in the same cycle
- running  out  1  1 in the RUN state
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- ovf  out  1  sticky: an input was dropped because the FIFO was full
- unf  out  1  sticky: a pop was due while the FIFO was empty
- in_cnt  out  32  valid_in pulses seen, dropped ones included
- out_cnt  out  32  dac_strobe pulses issued
- max_gap  out  16  largest cycle distance between consecutive valid_in, saturating at 0xFFFF

## Operation
- Conversion happens at FIFO write and the FIFO stores 16-bit words.
  - Compute t = (data_in + 64) >>> 7 as a 25-bit signed value. This is round-half-up on the 7 dropped fraction bits.
  - If t > 32767 the result is 0x7FFF. If t < −32768 the result is 0x8000. Otherwise the result is t[15:0].
- Write on valid_in:
  - If the FIFO is not full, the word is written.
  - If the FIFO is full and no pop happens that cycle, the word is dropped and ovf is set.
  - If the FIFO is full and a pop happens the same cycle, the write is accepted.
- Pointers wrap modulo DEPTH. Occupancy is tracked with an extra pointer bit so that full and empty are distinguishable.
- The state machine has two states, IDLE and RUN.
  - IDLE → RUN when the registered fifo_level ≥ PRIME. The pacer counter cnt is set to 0 on entry.
  - In RUN, cnt counts 0..INTERVAL−1 and wraps. A pop is due when cnt == 0.
  - A due pop with the FIFO non-empty reads the head word.
  - A due pop with the FIFO empty sets unf and moves the machine to IDLE (re-prime). No strobe is issued and dac_data holds its previous value.
- A write and a due pop in the same cycle while the FIFO is empty count as an underflow. There is no bypass path.
- in_cnt increments on every valid_in.
- max_gap:
  - The gap counter starts at the first valid_in after reset or clr. That first pulse does not update max_gap.
  - Each later pulse compares its distance to the previous pulse against max_gap and keeps the larger.
- If clr and an event occur in the same cycle, clr wins: the counters read 0 afterwards and the event is lost.

## Timing
- Reset values: dac_data=0, dac_strobe=0, running=0, fifo_level=0, ovf=0, unf=0, in_cnt=0, out_cnt=0, max_gap=0, state IDLE, FIFO empty.
- Asserting rst_n low mid-RUN clears everything immediately, including FIFO contents.
- fifo_level updates the cycle after a write or pop.
- dac_data, dac_strobe and out_cnt are registered and update the cycle after the pop.
- Startup latency: with the PRIME-th valid_in high in cycle c:
  - fifo_level reaches PRIME in cycle c+1.
  - running = 1 in cycle c+2, and the pop happens at the end of that cycle.
  - The first dac_strobe is high in cycle c+3.
- In RUN, consecutive dac_strobe pulses are exactly INTERVAL cycles apart, independent of input jitter.
- ovf and unf become visible the cycle after the offending event.

## Test plan
- Steady input (defaults), data_in=0x200000 every 10 cycles:
  - first strobe 3 cycles after the 4th input, dac_data=0x4000, strobes every 10 cycles;
  - after 100 inputs, out_cnt=100 − (level still buffered) and the level stays at 4;
  - ovf=0, unf=0, max_gap=10.
- Conversion checks:
  - 0x400000 → 0x7FFF and 0x3FFFC0 → 0x7FFF (saturation);
  - 0xC00000 → 0x8000;
  - 0x000040 → 0x0001 and 0x00003F → 0x0000;
  - 0xFFFFC0 → 0x0000 and 0xFFFFBF → 0xFFFF.
- Jitter: input gaps alternating 9 and 11 cycles → strobes exactly 10 apart, max_gap=11, no ovf/unf.
- Overflow: 12 back-to-back valid_in from reset, cycles 0..11 → one pop at cycle 5; inputs in cycles 9, 10 and 11 are dropped; ovf=1 from cycle 10; fifo_level=8; in_cnt=12.
- Underflow: stop input after 20 steady samples →
  - after the FIFO drains, the next due pop sets unf=1 and running=0, with dac_data holding the last word;
  - restarting input re-primes, and the first new strobe comes 3 cycles after the 4th new sample.
- Reset and clear:
  - rst_n low mid-RUN → all outputs 0 on the next observation, FIFO empty;
  - clr pulse with ovf=1 → ovf, counters and max_gap read 0 the next cycle, and fifo_level is unchanged.
